bandai_eeprom_ctrl: RTL
=======================

Name: bandai_eeprom_ctrl

Overview:
Microwire master for the cartridge save EEPROM (93C46-class, x16 organisation). It sits behind the mapper's I/O port decoder and serves console ports C4h–C8h. The block holds the data, command and control/status registers, and serialises start bit, opcode, address and data onto CS/SK/DI. It captures read data from DO and polls the ready/busy state after program or erase cycles.

Parameters:
CLKDIV, 4, CLK cycles per SK half-period (minimum 2)
ADDR_BITS, 6, EEPROM address width (6 for 93C46 x16)
BUSY_TIMEOUT, 4096, maximum SK periods spent polling ready before flagging an error

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
SEL  input  1  port window C4h–C8h decoded by the mapper
REG  input  3  register index (port minus C4h)
WR_STB  input  1  single-cycle write strobe, qualified by SEL
WDATA  input  8  write data
RDATA  output  8  combinational read mux of REG, valid whenever SEL=1, 00h otherwise
EE_CS  output  1  EEPROM chip select, active high
EE_SK  output  1  serial clock
EE_DI  output  1  serial data to EEPROM
EE_DO  input  1  serial data from EEPROM, ready/busy during poll
IRQ  output  1  one-CLK pulse when DONE sets

Behaviour:
- Reset: all outputs are 0, including EE_CS, EE_SK, EE_DI, RDATA and IRQ. All registers clear, the FSM goes to IDLE and the divider clears. An assertion mid-transfer drops CS/SK/DI asynchronously.
- Register map:
  - REG 0: DATA_LO.
  - REG 1: DATA_HI.
  - REG 2: ADDR, low ADDR_BITS bits used; unused bits read back 0.
  - REG 3: OPC[1:0]; unused bits read back 0.
  - REG 4: CTRL/STATUS. Write bits: [4] READ, [5] WRITE, [6] SHORT, [7] WAIT. Read bits: [0] BUSY, [1] DONE, [2] ERR; others read 0.
  - REG 5–7: read 00h, writes ignored.
- While BUSY=1, writes to REG 0–4 are ignored. On READ completion, the captured data replaces DATA_LO/HI.
- Command acceptance: a write to REG 4 with exactly one of bits [6:4] set clears DONE and ERR and sets BUSY on the next CLK.
  - Zero bits set: no-op.
  - Two or more bits set: ERR=1 and DONE=1, no transfer.
- Frame: 1 start bit '1', then OPC[1] and OPC[0], then ADDR MSB-first. That is FRAME = 3+ADDR_BITS bits.
  - WRITE appends DATA_HI:DATA_LO MSB-first (16 bits).
  - READ appends 16 capture bits.
  - SHORT has no data.
- Bit timing:
  - Each bit is a low half then a high half of SK, each CLKDIV cycles.
  - EE_DI changes only on the CLK where SK falls, or at the start of the low half.
  - EE_CS rises together with the first low half.
  - EE_DO is sampled on the CLK where SK goes 1->0.
  - The EEPROM's dummy 0 falls on the last address bit and is not captured; the 16 READ captures follow.
- FSM states: IDLE -> CMD (FRAME bits) -> WDATA or RDATA (16 bits), or straight on for SHORT -> END.
  - END: if WAIT=0, go to FINISH.
  - If WAIT=1: GAP (CS low, SK low, for 2*CLKDIV cycles), then POLL.
  - POLL: CS high, SK toggling. Exit when EE_DO is sampled 1.
  - POLL timeout: after BUSY_TIMEOUT SK periods, set ERR=1.
  - FINISH: CS low, DI low, BUSY=0, DONE=1, IRQ pulse; then IDLE.
- Latency with WAIT=0: BUSY=1 on cycle N+1 after the accepting write on cycle N. BUSY=0 and DONE=1 on cycle N+1+2*CLKDIV*(bits) exactly, where bits = FRAME+16 for READ/WRITE and FRAME for SHORT.
- SK idles low; SK never toggles while CS is low.
- A write to REG 4 arriving on the same cycle as FINISH is accepted on the following cycle. It is not lost: the block holds it as pending.

Test Plan:
- RST pulse mid-READ (at bit 5) -> CS/SK/DI are 0 within the same cycle; STATUS=00h; DATA regs=00h.
- ADDR=2Ah, OPC=2, CTRL=10h, model returns 1234h, CLKDIV=4 -> DI carries 1,1,0,1,0,1,0,1,0. BUSY drops exactly 200 CLKs after the write. DATA_LO=34h, DATA_HI=12h, STATUS=02h, one IRQ pulse.
- DATA=BEEFh, ADDR=05h, OPC=1, CTRL=A0h; model holds DO low for 37 SK periods -> 25-bit frame observed. A CS gap of 8 CLKs is followed by polling. DONE sets after DO=1; ERR=0.
- Same as the previous case but DO is stuck at 0 -> ERR=1 and DONE=1 after 4096 SK periods in POLL; CS low afterwards.
- CTRL=30h -> no CS activity; STATUS=06h. Then CTRL=00h -> STATUS unchanged.
- OPC=0, ADDR=30h (EWEN), CTRL=40h -> 9-bit frame 1,0,0,1,1,0,0,0,0. BUSY lasts 72 CLKs. A DATA_LO write during BUSY is ignored.

Source files
------------

// File: rtl/bandai_eeprom_ctrl.sv
// Microwire master for a 93C46-class (x16) save EEPROM behind the mapper I/O ports C4h-C8h.
// Holds DATA/ADDR/OPC/CTRL registers, shifts start+opcode+address(+data) out on CS/SK/DI,
// captures read data from DO and optionally polls ready/busy after program/erase cycles.
`timescale 1ns/1ps
module bandai_eeprom_ctrl #(
    parameter int unsigned CLKDIV       = 4,
    parameter int unsigned ADDR_BITS    = 6,
    parameter int unsigned BUSY_TIMEOUT = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SEL,
    input  logic [2:0] REG,
    input  logic       WR_STB,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       EE_CS,
    output logic       EE_SK,
    output logic       EE_DI,
    input  logic       EE_DO,
    output logic       IRQ
);
    localparam int unsigned FRAME   = 3 + ADDR_BITS;
    localparam int unsigned BIT_T   = 2 * CLKDIV;
    localparam int unsigned TQ_W    = $clog2(BIT_T);
    localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > FRAME + 16) ? BUSY_TIMEOUT : FRAME + 16;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WDATA, S_RDATA, S_GAP, S_POLL, S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [TQ_W-1:0]      tq_q, tq_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          data_q, data_d, sh_q, sh_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [1:0]           opc_q, opc_d;
    logic                 rd_q, rd_d, wr_q, wr_d, wait_q, wait_d;
    logic                 done_q, done_d, err_q, err_d, irq_q, irq_d;
    logic                 pend_q, pend_d;
    logic [3:0]           pend_cmd_q, pend_cmd_d;
    logic                 cs_q, cs_d, sk_q, sk_d, di_q, di_d;

    logic                 wr_c, busy_c, bit_end_c, end_c, finish_c;
    logic [3:0]           cmd_c;
    logic [FRAME-1:0]     frame_c, frame_sh_c;
    logic [15:0]          data_sh_c;

    assign wr_c      = SEL & WR_STB;
    assign busy_c    = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign bit_end_c = (tq_q == TQ_W'(BIT_T - 1));
    assign frame_c   = {1'b1, opc_q, addr_q};

    // State and register file; async reset drops the serial lines immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            tq_q       <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            opc_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wait_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_cmd_q <= '0;
            cs_q       <= 1'b0;
            sk_q       <= 1'b0;
            di_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tq_q       <= tq_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            opc_q      <= opc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            pend_q     <= pend_d;
            pend_cmd_q <= pend_cmd_d;
            cs_q       <= cs_d;
            sk_q       <= sk_d;
            di_q       <= di_d;
        end
    end

    // Next-state: register writes, command acceptance, bit sequencing and line levels
    always_comb begin
        state_d    = state_q;
        tq_d       = tq_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        opc_d      = opc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wait_d     = wait_q;
        done_d     = done_q;
        err_d      = err_q;
        irq_d      = 1'b0;
        pend_d     = pend_q;
        pend_cmd_d = pend_cmd_q;
        cmd_c      = 4'h0;
        end_c      = 1'b0;
        finish_c   = 1'b0;
        frame_sh_c = '0;
        data_sh_c  = '0;
        cs_d       = 1'b0;
        sk_d       = 1'b0;
        di_d       = 1'b0;

        if (wr_c && !busy_c) begin
            unique case (REG)
                3'd0:    data_d[7:0]  = WDATA;
                3'd1:    data_d[15:8] = WDATA;
                3'd2:    addr_d       = ADDR_BITS'(WDATA);
                3'd3:    opc_d        = WDATA[1:0];
                default: ;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                // A command parked during FINISH takes priority over a fresh write
                if (pend_q) begin
                    cmd_c  = pend_cmd_q;
                    pend_d = 1'b0;
                end else if (wr_c && REG == 3'd4) begin
                    cmd_c = WDATA[7:4];
                end
                unique case (cmd_c[2:0])
                    3'b000: ;
                    3'b001, 3'b010, 3'b100: begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        rd_d    = cmd_c[0];
                        wr_d    = cmd_c[1];
                        wait_d  = cmd_c[3];
                        tq_d    = '0;
                        cnt_d   = '0;
                        state_d = S_CMD;
                    end
                    default: begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                        irq_d  = 1'b1;
                    end
                endcase
            end
            S_CMD, S_WDATA, S_RDATA: begin
                tq_d = tq_q + TQ_W'(1);
                if (bit_end_c) begin
                    tq_d  = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == S_RDATA) begin
                        sh_d = {sh_q[14:0], EE_DO};
                    end
                    if (state_q == S_CMD) begin
                        if (cnt_q == CNT_W'(FRAME - 1)) begin
                            cnt_d = '0;
                            if (rd_q)      state_d = S_RDATA;
                            else if (wr_q) state_d = S_WDATA;
                            else           end_c   = 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(15)) begin
                        end_c = 1'b1;
                        if (state_q == S_RDATA) begin
                            data_d = {sh_q[14:0], EE_DO};
                        end
                    end
                end
            end
            S_GAP: begin
                tq_d = tq_q + TQ_W'(1);
                if (bit_end_c) begin
                    tq_d    = '0;
                    cnt_d   = '0;
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                tq_d = tq_q + TQ_W'(1);
                if (bit_end_c) begin
                    tq_d = '0;
                    if (EE_DO) begin
                        finish_c = 1'b1;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        err_d    = 1'b1;
                        finish_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (wr_c && REG == 3'd4) begin
                    pend_d     = 1'b1;
                    pend_cmd_d = WDATA[7:4];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // END decision: either a CS gap before polling, or straight to FINISH
        if (end_c) begin
            tq_d  = '0;
            cnt_d = '0;
            if (wait_q) state_d  = S_GAP;
            else        finish_c = 1'b1;
        end
        if (finish_c) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            irq_d   = 1'b1;
        end

        // Line levels for the coming cycle; DI only moves at bit boundaries
        unique case (state_d)
            S_CMD: begin
                cs_d       = 1'b1;
                sk_d       = (tq_d >= TQ_W'(CLKDIV));
                frame_sh_c = frame_c << cnt_d;
                di_d       = frame_sh_c[FRAME-1];
            end
            S_WDATA: begin
                cs_d      = 1'b1;
                sk_d      = (tq_d >= TQ_W'(CLKDIV));
                data_sh_c = data_q << cnt_d;
                di_d      = data_sh_c[15];
            end
            S_RDATA, S_POLL: begin
                cs_d = 1'b1;
                sk_d = (tq_d >= TQ_W'(CLKDIV));
            end
            default: ;
        endcase
    end

    // Combinational read mux of the port window
    always_comb begin
        RDATA = 8'h00;
        if (SEL) begin
            unique case (REG)
                3'd0:    RDATA = data_q[7:0];
                3'd1:    RDATA = data_q[15:8];
                3'd2:    RDATA = 8'(addr_q);
                3'd3:    RDATA = {6'b0, opc_q};
                3'd4:    RDATA = {5'b0, err_q, done_q, busy_c};
                default: RDATA = 8'h00;
            endcase
        end
    end

    assign EE_CS = cs_q;
    assign EE_SK = sk_q;
    assign EE_DI = di_q;
    assign IRQ   = irq_q;

endmodule
